// File: rtl/spi_axil_cmd_master_if.sv
// AXI-lite read/write channel bundle between the command master and the SPI register block.
interface spi_axil_cmd_master_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int STRB    = 4,
  parameter int PROTW   = 3,
  parameter int RESPLEN = 2
);
  logic [AW-1:0]      awaddr;
  logic [PROTW-1:0]   awprot;
  logic               awvalid;
  logic               awready;
  logic [DW-1:0]      wdata;
  logic [STRB-1:0]    wstrb;
  logic               wvalid;
  logic               wready;
  logic [RESPLEN-1:0] bresp;
  logic               bvalid;
  logic               bready;
  logic [AW-1:0]      araddr;
  logic [PROTW-1:0]   arprot;
  logic               arvalid;
  logic               arready;
  logic [DW-1:0]      rdata;
  logic [RESPLEN-1:0] rresp;
  logic               rvalid;
  logic               rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/spi_axil_cmd_master.sv
// Turns one host read/write command into a single AXI-lite transaction and returns the response.
// Optional B/R response timeout enabled by defining SPI_AXIL_TIMEOUT_EN.
module spi_axil_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int STRB    = 4,
  parameter int PROTW   = 3,
  parameter int RESPLEN = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [DW-1:0]      cmd_wdata,
  input  logic [STRB-1:0]    cmd_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic [RESPLEN-1:0] rsp_resp,
  output logic               rsp_timeout,
  spi_axil_cmd_master_if.master axil
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state;

`ifdef SPI_AXIL_TIMEOUT_EN
  // Holds 0..TIMEOUT-2; the last value is the expiry cycle.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;
  logic [CW-1:0] tmo_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready   = rst_n && (state == IDLE);
  assign axil.awprot = '0;
  assign axil.arprot = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      axil.awaddr  <= '0;
      axil.awvalid <= 1'b0;
      axil.wdata   <= '0;
      axil.wstrb   <= '0;
      axil.wvalid  <= 1'b0;
      axil.bready  <= 1'b0;
      axil.araddr  <= '0;
      axil.arvalid <= 1'b0;
      axil.rready  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= '0;
`ifdef SPI_AXIL_TIMEOUT_EN
      rsp_timeout  <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_write) begin
            axil.awaddr  <= cmd_addr;
            axil.wdata   <= cmd_wdata;
            axil.wstrb   <= cmd_wstrb;
            axil.awvalid <= 1'b1;
            axil.wvalid  <= 1'b1;
            state        <= WR_AW_W;
          end else begin
            axil.araddr  <= cmd_addr;
            axil.arvalid <= 1'b1;
            state        <= RD_AR;
          end
        end
        WR_AW_W: begin
          if (axil.awready) axil.awvalid <= 1'b0;
          if (axil.wready)  axil.wvalid  <= 1'b0;
          // Each channel is done if already handshaken or handshaking now.
          if ((!axil.awvalid || axil.awready) && (!axil.wvalid || axil.wready)) begin
            axil.bready <= 1'b1;
            state       <= WR_B;
`ifdef SPI_AXIL_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        WR_B: begin
          if (axil.bvalid) begin
            axil.bready <= 1'b0;
            rsp_resp    <= axil.bresp;
            rsp_rdata   <= '0;
            rsp_valid   <= 1'b1;
            state       <= RSP;
`ifdef SPI_AXIL_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (tmo_cnt == CW'(TIMEOUT - 2)) begin
            axil.bready <= 1'b0;
            rsp_resp    <= RESPLEN'(2'b10);
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RSP;
          end else begin
            tmo_cnt     <= tmo_cnt + 1'b1;
`endif
          end
        end
        RD_AR: if (axil.arready) begin
          axil.arvalid <= 1'b0;
          axil.rready  <= 1'b1;
          state        <= RD_R;
`ifdef SPI_AXIL_TIMEOUT_EN
          tmo_cnt      <= '0;
`endif
        end
        RD_R: begin
          if (axil.rvalid) begin
            axil.rready <= 1'b0;
            rsp_resp    <= axil.rresp;
            rsp_rdata   <= axil.rdata;
            rsp_valid   <= 1'b1;
            state       <= RSP;
`ifdef SPI_AXIL_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (tmo_cnt == CW'(TIMEOUT - 2)) begin
            axil.rready <= 1'b0;
            rsp_resp    <= RESPLEN'(2'b10);
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RSP;
          end else begin
            tmo_cnt     <= tmo_cnt + 1'b1;
`endif
          end
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_axil_cmd_master.sv
// Self-checking bench: a cycle-level AXI-lite slave with programmable delays and an arithmetic latency/response model.
module tb_spi_axil_cmd_master;
  localparam int TMO    = 8;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int vectors = 0;
  int miscompares = 0;

  spi_axil_cmd_master_if #(.AW(32), .DW(32), .STRB(4), .PROTW(3), .RESPLEN(2)) axil ();

  spi_axil_cmd_master #(
    .AW(32), .DW(32), .STRB(4), .PROTW(3), .RESPLEN(2), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axil(axil)
  );

  always #5 clk = ~clk;

  task automatic slave_idle();
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    axil.arready = 1'b0;
    axil.bvalid  = 1'b0;
    axil.rvalid  = 1'b0;
    axil.bresp   = 2'($urandom);
    axil.rresp   = 2'($urandom);
    axil.rdata   = $urandom;
  endtask

  // Entered and left just after a falling edge. Delays: cycles of visible valid/ready before the slave answers.
  task automatic run_txn(input string nm, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb,
                         input int aw_d, input int w_d, input int ar_d, input int rsp_d,
                         input logic [1:0] resp, input logic [31:0] rd, input int hold);
    bit exp_to;
    int ph, exp_lat, exp_rdy, exp_dhs;
    logic [1:0]  exp_resp, got_resp;
    logic [31:0] exp_rdata, got_rdata;
    logic        got_to;
    int rsp_cyc, aw_cnt, w_cnt, ar_cnt, d_cnt, aw_hs, w_hs, ar_hs, d_hs, rdy_cyc;
    bit aw_seen, w_seen, ar_seen, proto_err, stable_err;

    exp_to = 1'b0;
`ifdef SPI_AXIL_TIMEOUT_EN
    exp_to = (rsp_d >= TMO - 1);
`endif
    ph        = wr ? ((aw_d > w_d) ? aw_d : w_d) : ar_d;
    exp_lat   = exp_to ? (1 + ph + TMO) : (3 + ph + rsp_d);
    exp_rdy   = exp_to ? (TMO - 1) : (rsp_d + 1);
    exp_dhs   = exp_to ? 0 : 1;
    exp_resp  = exp_to ? 2'b10 : resp;
    exp_rdata = (exp_to || wr) ? 32'h0 : rd;

    rsp_cyc = -1; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; d_cnt = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; d_hs = 0; rdy_cyc = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; proto_err = 0; stable_err = 0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s cmd_ready: got %b want 1", nm, cmd_ready);
    end

    for (int cyc = 1; cyc <= BUDGET && rsp_cyc < 0; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      slave_idle();
      if (rsp_valid) begin
        rsp_cyc = cyc;
      end else begin
        if (wr && (axil.arvalid || axil.rready)) proto_err = 1;
        if (!wr && (axil.awvalid || axil.wvalid || axil.bready)) proto_err = 1;
        if (axil.awvalid) begin
          aw_seen = 1;
          if (aw_hs != 0 || axil.awaddr !== addr || axil.awprot !== 3'b000) proto_err = 1;
          if (aw_cnt == aw_d) begin axil.awready = 1'b1; aw_hs++; end else aw_cnt++;
        end else if (aw_seen && aw_hs == 0) proto_err = 1;
        if (axil.wvalid) begin
          w_seen = 1;
          if (w_hs != 0 || axil.wdata !== wd || axil.wstrb !== strb) proto_err = 1;
          if (w_cnt == w_d) begin axil.wready = 1'b1; w_hs++; end else w_cnt++;
        end else if (w_seen && w_hs == 0) proto_err = 1;
        if (axil.arvalid) begin
          ar_seen = 1;
          if (ar_hs != 0 || axil.araddr !== addr || axil.arprot !== 3'b000) proto_err = 1;
          if (ar_cnt == ar_d) begin axil.arready = 1'b1; ar_hs++; end else ar_cnt++;
        end else if (ar_seen && ar_hs == 0) proto_err = 1;
        if (wr ? axil.bready : axil.rready) begin
          rdy_cyc++;
          if (d_cnt == rsp_d) begin
            if (wr) begin axil.bvalid = 1'b1; axil.bresp = resp; end
            else begin axil.rvalid = 1'b1; axil.rdata = rd; axil.rresp = resp; end
            d_hs++;
          end else d_cnt++;
        end
      end
    end

    vectors++;
    if (rsp_cyc !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", nm, rsp_cyc, exp_lat);
    end
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s axi_protocol: got violation want none", nm);
    end
    vectors++;
    if ((wr ? (aw_hs * 10 + w_hs) : ar_hs) !== (wr ? 11 : 1)) begin
      miscompares++;
      $display("FAIL %s addr_handshakes: got aw=%0d w=%0d ar=%0d want one each", nm, aw_hs, w_hs, ar_hs);
    end
    vectors++;
    if (d_hs !== exp_dhs || rdy_cyc !== exp_rdy) begin
      miscompares++;
      $display("FAIL %s resp_channel: got hs=%0d ready_cycles=%0d want hs=%0d ready_cycles=%0d",
               nm, d_hs, rdy_cyc, exp_dhs, exp_rdy);
    end
    vectors++;
    if (rsp_resp !== exp_resp || rsp_rdata !== exp_rdata || rsp_timeout !== exp_to) begin
      miscompares++;
      $display("FAIL %s response: got resp=%b rdata=%h to=%b want resp=%b rdata=%h to=%b",
               nm, rsp_resp, rsp_rdata, rsp_timeout, exp_resp, exp_rdata, exp_to);
    end

    got_resp = rsp_resp; got_rdata = rsp_rdata; got_to = rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (exp_to) begin
        // Late response after expiry must not disturb the held result.
        axil.bvalid = wr; axil.rvalid = !wr; axil.rdata = $urandom; axil.bresp = 2'b01; axil.rresp = 2'b01;
      end
      @(negedge clk);
      slave_idle();
      if (rsp_valid !== 1'b1 || rsp_resp !== got_resp || rsp_rdata !== got_rdata || rsp_timeout !== got_to)
        stable_err = 1;
    end
    vectors++;
    if (stable_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s rsp_hold: got payload change or drop want stable for %0d cycles", nm, hold);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s release: got rsp_valid=%b cmd_ready=%b want 0 1", nm, rsp_valid, cmd_ready);
    end

    if (rsp_cyc < 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_timeout, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 8'h00
        || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || axil.awaddr !== 32'h0 || axil.araddr !== 32'h0
        || axil.wdata !== 32'h0 || axil.wstrb !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: got nonzero output (cmd_ready=%b rsp_valid=%b awvalid=%b) want all 0",
               cmd_ready, rsp_valid, axil.awvalid);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    run_txn("write_zero_wait", 1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0);
  endtask

  task automatic test_write_w_delayed();
    run_txn("write_w_delayed", 1'b1, 32'h0000_0020, 32'h1357_9BDF, 4'h5, 0, 4, 0, 1, 2'b00, 32'h0, 1);
  endtask

  task automatic test_read_wait();
    run_txn("read_wait", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 2, 2'b00, 32'h0000_00C3, 3);
  endtask

`ifdef SPI_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    run_txn("read_timeout", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 1, 1000, 2'b00, 32'hDEAD_BEEF, 2);
    run_txn("after_timeout", 1'b0, 32'h0000_000C, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h1111_2222, 0);
    run_txn("write_timeout", 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 1, 0, 0, 1000, 2'b00, 32'h0, 2);
    run_txn("read_expiry_edge", 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, TMO - 2, 2'b01, 32'h0BAD_CAFE, 1);
    run_txn("write_expiry_edge", 1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 4'hC, 0, 2, 0, TMO - 2, 2'b11, 32'h0, 0);
  endtask
`else
  task automatic test_no_timeout();
    run_txn("read_long_wait", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 1, 20, 2'b00, 32'h7777_8888, 1);
    run_txn("write_long_wait", 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 1, 0, 0, 20, 2'b10, 32'h0, 0);
  endtask
`endif

  task automatic test_reset_midtxn();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h2468_ACE0; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (axil.awvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got awvalid=%b want 1", axil.awvalid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, rsp_valid, cmd_ready} !== 7'h00
        || axil.awaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got aw=%b w=%b ar=%b cmd_ready=%b awaddr=%h want all 0",
               axil.awvalid, axil.wvalid, axil.arvalid, cmd_ready, axil.awaddr);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_hold: got cmd_ready=%b want 0", cmd_ready);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_release: got cmd_ready=%b want 1", cmd_ready);
    end
    run_txn("after_reset", 1'b1, 32'h0000_0054, 32'h8642_0000, 4'h9, 0, 0, 0, 0, 2'b00, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_txn("back_to_back", 1'(i), $urandom, $urandom, 4'($urandom), 0, 0, 0, 0, 2'($urandom), $urandom, 0);
  endtask

  task automatic test_random();
    int maxd;
`ifdef SPI_AXIL_TIMEOUT_EN
    maxd = TMO + 1;
`else
    maxd = 5;
`endif
    for (int i = 0; i < 30; i++)
      run_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, maxd),
              2'($urandom), $urandom, $urandom_range(0, 2));
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    slave_idle();
    test_reset();
    test_write_zero_wait();
    test_write_w_delayed();
    test_read_wait();
`ifdef SPI_AXIL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_midtxn();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
